// File: rtl/alut_addr_lookup19_pkg.sv
// Shared definitions for the ALUT address lookup: FSM states, RAM entry layout,
// broadcast MAC and egress-mask helpers.
package alut_pkg19;

    localparam int unsigned MAC_W   = 48;
    localparam int unsigned TIME_W  = 32;
    localparam int unsigned ENTRY_W = 83;

    // Highest ALUT RAM address, also used by the age checker.
    localparam logic [7:0]  MAX_ADDR = 8'hFF;
    localparam int unsigned ADDR_W   = $clog2(int'(MAX_ADDR) + 1);

    localparam int unsigned VALID_BIT = 82;
    localparam int unsigned TIME_MSB  = 81;
    localparam int unsigned TIME_LSB  = 50;
    localparam int unsigned PORT_MSB  = 49;
    localparam int unsigned PORT_LSB  = 48;

    localparam logic [MAC_W-1:0] BCAST_MAC = '1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT_AGE,
        ST_SA_WR,
        ST_DA_RD,
        ST_DA_CHK,
        ST_AGE_REQ,
        ST_AGE_WAIT,
        ST_RESULT
    } lookup_state_e;

    // Every port except the one the frame arrived on.
    function automatic logic [3:0] flood_mask(input logic [1:0] src_port);
        return 4'b1111 & ~(4'b0001 << src_port);
    endfunction

    // Known destination; a frame is never sent back out of its ingress port.
    function automatic logic [3:0] hit_mask(input logic [1:0] hit_port,
                                            input logic [1:0] src_port);
        return (hit_port == src_port) ? 4'b0000 : (4'b0001 << hit_port);
    endfunction

endpackage

// File: rtl/alut_addr_lookup19_mac_hash.sv
// 48-to-8 XOR fold of a MAC address, giving the ALUT RAM index.
module alut_mac_hash19
    import alut_pkg19::*;
(
    input  logic [MAC_W-1:0]  mac_i,
    output logic [ADDR_W-1:0] idx_o
);

    always_comb begin
        idx_o = '0;
        for (int unsigned i = 0; i < 6; i++) begin
            idx_o ^= mac_i[i*8 +: 8];
        end
    end

endmodule

// File: rtl/alut_addr_lookup19.sv
// ALUT frame lookup: learns the source MAC, looks up the destination MAC and
// resolves a one-hot / flood / filter egress mask, consulting the age checker on a hit.
module alut_addr_lookup19
    import alut_pkg19::*;
#(
    parameter int unsigned AGE_TMO = 16
) (
    input  logic                pclk19,
    input  logic                n_p_reset19,
    input  logic                d_addr_vld19,
    input  logic [MAC_W-1:0]    d_addr19,
    input  logic [MAC_W-1:0]    s_addr19,
    input  logic [1:0]          s_port19,
    input  logic [TIME_W-1:0]   curr_time19,
    input  logic                age_check_active19,
    input  logic                age_confirmed19,
    input  logic                age_ok19,
    input  logic [ENTRY_W-1:0]  mem_read_data_add19,
    output logic [ADDR_W-1:0]   mem_addr_add19,
    output logic                mem_write_add19,
    output logic [ENTRY_W-1:0]  mem_write_data_add19,
    output logic                check_age19,
    output logic [TIME_W-1:0]   last_accessed19,
    output logic                add_check_active19,
    output logic [3:0]          d_port19,
    output logic                d_port_vld19,
    output logic                addr_busy19
);

    localparam logic [7:0] AGE_CNT_LAST = 8'(AGE_TMO - 1);

    lookup_state_e     state_q;
    logic [MAC_W-1:0]  d_addr_q;
    logic [MAC_W-1:0]  s_addr_q;
    logic [1:0]        s_port_q;
    logic [1:0]        hit_port_q;
    logic [7:0]        age_cnt_q;

    logic [MAC_W-1:0]  src_mac;
    logic [1:0]        src_port;
    logic [ADDR_W-1:0] src_idx;
    logic [ADDR_W-1:0] dst_idx;
    logic              da_miss;

    // The learn write is issued on the edge leaving IDLE (straight from the
    // inputs) or leaving WAIT_AGE (from the captured copy), so outputs stay registered.
    always_comb begin
        src_mac  = (state_q == ST_IDLE) ? s_addr19 : s_addr_q;
        src_port = (state_q == ST_IDLE) ? s_port19 : s_port_q;
        da_miss  = (d_addr_q == BCAST_MAC)
                || !mem_read_data_add19[VALID_BIT]
                || (mem_read_data_add19[PORT_LSB-1:0] != d_addr_q);
    end

    alut_mac_hash19 u_src_hash (
        .mac_i (src_mac),
        .idx_o (src_idx)
    );

    alut_mac_hash19 u_dst_hash (
        .mac_i (d_addr_q),
        .idx_o (dst_idx)
    );

    always_ff @(posedge pclk19 or negedge n_p_reset19) begin
        if (!n_p_reset19) begin
            state_q              <= ST_IDLE;
            d_addr_q             <= '0;
            s_addr_q             <= '0;
            s_port_q             <= '0;
            hit_port_q           <= '0;
            age_cnt_q            <= '0;
            mem_addr_add19       <= '0;
            mem_write_add19      <= 1'b0;
            mem_write_data_add19 <= '0;
            check_age19          <= 1'b0;
            last_accessed19      <= '0;
            add_check_active19   <= 1'b0;
            d_port19             <= '0;
            d_port_vld19         <= 1'b0;
            addr_busy19          <= 1'b0;
        end else begin
            mem_write_add19      <= 1'b0;
            mem_write_data_add19 <= '0;
            check_age19          <= 1'b0;
            d_port_vld19         <= 1'b0;

            case (state_q)
                ST_IDLE: begin
                    if (d_addr_vld19) begin
                        d_addr_q    <= d_addr19;
                        s_addr_q    <= s_addr19;
                        s_port_q    <= s_port19;
                        addr_busy19 <= 1'b1;
                        if (age_check_active19) begin
                            state_q <= ST_WAIT_AGE;
                        end else begin
                            state_q              <= ST_SA_WR;
                            mem_addr_add19       <= src_idx;
                            mem_write_add19      <= 1'b1;
                            mem_write_data_add19 <= {1'b1, curr_time19, src_port, src_mac};
                        end
                    end
                end

                ST_WAIT_AGE: begin
                    if (!age_check_active19) begin
                        state_q              <= ST_SA_WR;
                        mem_addr_add19       <= src_idx;
                        mem_write_add19      <= 1'b1;
                        mem_write_data_add19 <= {1'b1, curr_time19, src_port, src_mac};
                    end
                end

                ST_SA_WR: begin
                    state_q        <= ST_DA_RD;
                    mem_addr_add19 <= dst_idx;
                end

                ST_DA_RD: begin
                    state_q <= ST_DA_CHK;
                end

                ST_DA_CHK: begin
                    if (da_miss) begin
                        state_q      <= ST_RESULT;
                        d_port19     <= flood_mask(s_port_q);
                        d_port_vld19 <= 1'b1;
                    end else begin
                        state_q            <= ST_AGE_REQ;
                        last_accessed19    <= mem_read_data_add19[TIME_MSB:TIME_LSB];
                        hit_port_q         <= mem_read_data_add19[PORT_MSB:PORT_LSB];
                        check_age19        <= 1'b1;
                        add_check_active19 <= 1'b1;
                    end
                end

                ST_AGE_REQ: begin
                    state_q   <= ST_AGE_WAIT;
                    age_cnt_q <= '0;
                end

                ST_AGE_WAIT: begin
                    if (age_confirmed19 || (age_cnt_q == AGE_CNT_LAST)) begin
                        state_q            <= ST_RESULT;
                        add_check_active19 <= 1'b0;
                        d_port_vld19       <= 1'b1;
                        d_port19           <= (age_confirmed19 && age_ok19)
                                              ? hit_mask(hit_port_q, s_port_q)
                                              : flood_mask(s_port_q);
                    end else begin
                        age_cnt_q <= age_cnt_q + 8'd1;
                    end
                end

                ST_RESULT: begin
                    state_q     <= ST_IDLE;
                    addr_busy19 <= 1'b0;
                end

                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alut_addr_lookup19.sv
// Directed bench for alut_addr_lookup19 with a behavioural MAC-table model,
// a RAM model and a single per-cycle compare process.
module tb_alut_addr_lookup19;

    localparam logic [47:0] BCAST = 48'hFFFF_FFFF_FFFF;
    localparam logic [47:0] DA_A  = 48'h0A00_0000_0000;

    logic        pclk19 = 1'b0;
    logic        n_p_reset19;
    logic        d_addr_vld19;
    logic [47:0] d_addr19, s_addr19;
    logic [1:0]  s_port19;
    logic [31:0] curr_time19;
    logic        age_check_active19, age_confirmed19, age_ok19;
    logic [82:0] rd_q;
    logic [7:0]  mem_addr_add19;
    logic        mem_write_add19;
    logic [82:0] mem_write_data_add19;
    logic        check_age19;
    logic [31:0] last_accessed19;
    logic        add_check_active19;
    logic [3:0]  d_port19;
    logic        d_port_vld19;
    logic        addr_busy19;

    always #5 pclk19 = ~pclk19;

    alut_addr_lookup19 #(.AGE_TMO(16)) dut (
        .pclk19               (pclk19),
        .n_p_reset19          (n_p_reset19),
        .d_addr_vld19         (d_addr_vld19),
        .d_addr19             (d_addr19),
        .s_addr19             (s_addr19),
        .s_port19             (s_port19),
        .curr_time19          (curr_time19),
        .age_check_active19   (age_check_active19),
        .age_confirmed19      (age_confirmed19),
        .age_ok19             (age_ok19),
        .mem_read_data_add19  (rd_q),
        .mem_addr_add19       (mem_addr_add19),
        .mem_write_add19      (mem_write_add19),
        .mem_write_data_add19 (mem_write_data_add19),
        .check_age19          (check_age19),
        .last_accessed19      (last_accessed19),
        .add_check_active19   (add_check_active19),
        .d_port19             (d_port19),
        .d_port_vld19         (d_port_vld19),
        .addr_busy19          (addr_busy19)
    );

    // Synchronous-read RAM: data appears the cycle after the address is presented.
    logic [82:0] ram [256];
    always @(posedge pclk19) begin
        if (mem_write_add19) ram[mem_addr_add19] <= mem_write_data_add19;
        rd_q <= ram[mem_addr_add19];
    end

    // Behavioural MAC table, indexed by hash.
    bit          m_valid [256];
    logic [31:0] m_time  [256];
    logic [1:0]  m_port  [256];
    logic [47:0] m_mac   [256];

    int total = 0;
    int bad   = 0;

    logic [7:0]  exp_wr_idx;
    logic [82:0] exp_wr_data;
    logic [31:0] exp_time;
    logic [3:0]  exp_mask;
    int          wr_seen, ca_seen, vld_seen;
    logic [7:0]  last_wr_addr;
    logic [82:0] last_wr_data;
    logic [3:0]  got_mask;
    logic [31:0] got_la;
    int          got_lat;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] expv);
        total++;
        if (act !== expv) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, expv, $time);
        end
    endtask

    function automatic logic [7:0] h8(input logic [47:0] m);
        logic [7:0] r = '0;
        for (int i = 0; i < 6; i++) r ^= m[i*8 +: 8];
        return r;
    endfunction

    function automatic logic any_out();
        return |{mem_addr_add19, mem_write_add19, mem_write_data_add19, check_age19,
                 last_accessed19, add_check_active19, d_port19, d_port_vld19, addr_busy19};
    endfunction

    // Compare process: every cycle out of reset.
    always @(negedge pclk19) begin
        if (n_p_reset19) begin
            if (mem_write_add19) begin
                wr_seen++;
                last_wr_addr = mem_addr_add19;
                last_wr_data = mem_write_data_add19;
                chk("wr_addr", 128'(mem_addr_add19), 128'(exp_wr_idx));
                chk("wr_data", 128'(mem_write_data_add19), 128'(exp_wr_data));
            end else begin
                chk("wdata_idle", 128'(mem_write_data_add19), 128'd0);
            end
            if (check_age19) begin
                ca_seen++;
                chk("last_acc", 128'(last_accessed19), 128'(exp_time));
            end
            if (d_port_vld19) begin
                vld_seen++;
                chk("d_port", 128'(d_port19), 128'(exp_mask));
            end
            if (add_check_active19) chk("act_in_busy", 128'(addr_busy19), 128'd1);
        end
    end

    // resp: 0 = age ok, 1 = aged, 2 = no reply. busy_cyc: age checker busy cycles.
    // rst_at: cycle to pulse reset (-1 none).
    task automatic frame(input logic [47:0] s, input logic [1:0] sp, input logic [47:0] d,
                         input logic [31:0] t, input int resp, input int busy_cyc,
                         input int rst_at);
        int n = 0;
        int ca_n = -1;
        int vld_n = -1;
        bit busy_bad = 0;
        bit early = 0;
        bit aborted = 0;
        bit hit;
        logic [7:0] hi;

        @(negedge pclk19); #2;
        exp_wr_idx  = h8(s);
        exp_wr_data = {1'b1, t, sp, s};
        m_valid[h8(s)] = 1'b1;
        m_time[h8(s)]  = t;
        m_port[h8(s)]  = sp;
        m_mac[h8(s)]   = s;
        hi       = h8(d);
        hit      = (d != BCAST) && m_valid[hi] && (m_mac[hi] == d);
        exp_time = m_time[hi];
        if (!hit || resp != 0)     exp_mask = 4'hF & ~(4'b0001 << sp);
        else if (m_port[hi] == sp) exp_mask = 4'b0000;
        else                       exp_mask = 4'b0001 << m_port[hi];

        wr_seen = 0; ca_seen = 0; vld_seen = 0;
        got_la = '0; got_mask = 'x;
        curr_time19 = t; s_addr19 = s; s_port19 = sp; d_addr19 = d;
        d_addr_vld19 = 1'b1;
        age_check_active19 = (busy_cyc > 0);

        while (vld_n < 0 && n < 64 && !aborted) begin
            @(negedge pclk19); #2;
            n++;
            d_addr_vld19 = 1'b0;
            age_confirmed19 = 1'b0;
            age_ok19 = 1'b0;
            if (age_check_active19 && wr_seen != 0) early = 1;
            if (n >= busy_cyc) age_check_active19 = 1'b0;
            if (!addr_busy19) busy_bad = 1;
            if (check_age19) begin
                ca_n = n;
                got_la = last_accessed19;
            end
            if (d_port_vld19) begin
                vld_n = n;
                got_mask = d_port19;
            end else if (ca_n > 0 && n == ca_n + 1 && resp != 2) begin
                age_confirmed19 = 1'b1;
                age_ok19 = (resp == 0);
            end
            // A second request mid-lookup must be ignored.
            if (resp == 2 && rst_at < 0 && n == 10) begin
                d_addr_vld19 = 1'b1;
                d_addr19 = BCAST;
            end
            if (n == rst_at) begin
                n_p_reset19 = 1'b0;
                #1;
                chk("rst_async_outs", 128'(any_out()), 128'd0);
                @(negedge pclk19); #2;
                chk("rst_next_outs", 128'(any_out()), 128'd0);
                n_p_reset19 = 1'b1;
                aborted = 1;
            end
        end

        chk("busy_during", 128'(busy_bad), 128'd0);
        chk("wr_once", 128'(wr_seen), 128'd1);
        chk("early_wr", 128'(early), 128'd0);
        if (aborted) begin
            chk("ca_before_rst", 128'(ca_seen), 128'(hit));
            repeat (3) begin
                @(negedge pclk19); #2;
                chk("no_vld_after_rst", 128'(d_port_vld19), 128'd0);
                chk("idle_after_rst", 128'(addr_busy19), 128'd0);
            end
        end else begin
            chk("vld_arrived", 128'(vld_n >= 0), 128'd1);
            chk("ca_count", 128'(ca_seen), 128'(hit));
            chk("vld_once", 128'(vld_seen), 128'd1);
            if (ca_n > 0 && resp != 2 && vld_n > 0)
                chk("hit_lat_bound", 128'((vld_n - ca_n) <= 4), 128'd1);
            @(negedge pclk19); #2;
            chk("hold_dport", 128'(d_port19), 128'(got_mask));
            chk("vld_drop", 128'(d_port_vld19), 128'd0);
            chk("idle_busy", 128'(addr_busy19), 128'd0);
        end
        got_lat = vld_n;
    endtask

    initial begin
        n_p_reset19 = 1'b0;
        d_addr_vld19 = 1'b0; d_addr19 = '0; s_addr19 = '0; s_port19 = '0;
        curr_time19 = '0; age_check_active19 = 1'b0;
        age_confirmed19 = 1'b0; age_ok19 = 1'b0;
        exp_wr_idx = '0; exp_wr_data = '0; exp_time = '0; exp_mask = '0;
        wr_seen = 0; ca_seen = 0; vld_seen = 0;
        for (int i = 0; i < 256; i++) begin
            ram[i] = '0;
            m_valid[i] = 1'b0;
            m_time[i] = '0;
            m_port[i] = '0;
            m_mac[i] = '0;
        end

        repeat (3) @(negedge pclk19);
        #1;
        chk("reset_outs", 128'(any_out()), 128'd0);
        chk("reset_dport", 128'(d_port19), 128'd0);
        #1 n_p_reset19 = 1'b1;

        // Empty table: learn write at index 0x01, flood without port 1.
        frame(48'h0000_0000_0001, 2'd1, 48'h0000_0000_0002, 32'd100, 0, 0, -1);
        chk("r039_wr_addr", 128'(last_wr_addr), 128'h01);
        chk("r039_wr_data", 128'(last_wr_data), 128'({1'b1, 32'd100, 2'd1, 48'h0000_0000_0001}));
        chk("r039_mask", 128'(got_mask), 128'b1101);
        chk("r039_lat", 128'(got_lat), 128'd4);

        // Learn DA_A on port 2 via a broadcast frame.
        frame(DA_A, 2'd2, BCAST, 32'd200, 0, 0, -1);
        chk("bcast_p2_mask", 128'(got_mask), 128'b1011);
        chk("bcast_p2_lat", 128'(got_lat), 128'd4);

        // Hit, in date.
        frame(48'h0000_0000_0001, 2'd0, DA_A, 32'd300, 0, 0, -1);
        chk("hit_ok_mask", 128'(got_mask), 128'b0100);
        chk("hit_ok_la", 128'(got_la), 128'd200);

        // Hit, aged.
        frame(48'h0000_0000_0001, 2'd0, DA_A, 32'd310, 1, 0, -1);
        chk("hit_aged_mask", 128'(got_mask), 128'b1110);

        // Age checker busy for 20 cycles at request.
        frame(48'h0000_0000_0003, 2'd3, DA_A, 32'd320, 0, 20, -1);
        chk("contend_mask", 128'(got_mask), 128'b0100);
        chk("contend_wr_addr", 128'(last_wr_addr), 128'h03);

        // No age reply: timeout after 16 cycles in AGE_WAIT.
        frame(48'h0000_0000_0005, 2'd1, DA_A, 32'd330, 2, 0, -1);
        chk("tmo_mask", 128'(got_mask), 128'b1101);
        chk("tmo_lat", 128'(got_lat), 128'd21);

        // Broadcast from port 3.
        frame(48'h0000_0000_0007, 2'd3, BCAST, 32'd340, 0, 0, -1);
        chk("bcast_p3_mask", 128'(got_mask), 128'b0111);
        chk("bcast_p3_lat", 128'(got_lat), 128'd4);

        // Destination lives on the ingress port: filtered.
        frame(48'h0C00_0000_0000, 2'd2, DA_A, 32'd350, 0, 0, -1);
        chk("filter_mask", 128'(got_mask), 128'b0000);

        // Source and destination collide on index 0xFF: just-written entry misses.
        frame(48'h0000_0000_00FF, 2'd1, 48'h0000_0000_FF00, 32'd360, 0, 0, -1);
        chk("collide_mask", 128'(got_mask), 128'b1101);
        chk("collide_lat", 128'(got_lat), 128'd4);

        // Source equals destination: hits its own fresh entry, then filtered.
        frame(48'h0000_0000_0011, 2'd1, 48'h0000_0000_0011, 32'd370, 0, 0, -1);
        chk("self_mask", 128'(got_mask), 128'b0000);
        chk("self_la", 128'(got_la), 128'd370);

        // Reset pulsed while in AGE_WAIT, then a normal lookup.
        frame(48'h0000_0000_0021, 2'd0, DA_A, 32'd380, 2, 0, 8);
        frame(48'h0000_0000_0001, 2'd0, DA_A, 32'd390, 0, 0, -1);
        chk("post_rst_mask", 128'(got_mask), 128'b0100);
        chk("post_rst_la", 128'(got_la), 128'd200);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
